lcd_frame_scheduler: RTL

LCD_FRAME_SCHEDULER -- requirements
Module: lcd_frame_scheduler

---
 rtl/lcd_sched_pkg.sv | 41 ++++
 rtl/lcd_pix_pack.sv | 34 +++
 rtl/lcd_frame_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_sched_pkg.sv
// Shared state type, panel opcodes and pixel format constants for lcd_frame_scheduler.
// Defining LCD_SCHED_RGB666_EN selects 3-byte RGB666 pixels instead of 2-byte RGB565.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHost,
    StCaset,
    StPaset,
    StRamwr,
    StPixel,
    StFrameEnd
  } sched_state_e;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

`ifdef LCD_SCHED_RGB666_EN
  localparam int unsigned BYTES_PER_PIX = 3;
`else
  localparam int unsigned BYTES_PER_PIX = 2;
`endif

  localparam int unsigned BIDX_W = (BYTES_PER_PIX > 2) ? 2 : 1;
  typedef logic [BIDX_W-1:0] byte_idx_t;

  // Window commands carry four parameter bytes after the opcode (index 1..4).
  localparam logic [2:0] WIN_LAST = 3'd4;

  function automatic logic [7:0] win_param(input logic [15:0] last, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd3:    b = last[15:8];
      3'd4:    b = last[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_pix_pack.sv
// Maps a 24-bit {R,G,B} pixel and a byte index to the byte sent on the panel bus.
// LCD_SCHED_RGB666_EN selects RGB666 (3 bytes); otherwise RGB565 (2 bytes).
module lcd_pix_pack
  import lcd_sched_pkg::*;
(
  input  logic [23:0] pixel,
  input  byte_idx_t   byte_idx,
  output logic [7:0]  pix_byte
);

`ifdef LCD_SCHED_RGB666_EN
  logic unused_bits;
  assign unused_bits = ^{pixel[17:16], pixel[9:8], pixel[1:0]};

  always_comb begin
    pix_byte = 8'h00;
    case (byte_idx)
      2'd0:    pix_byte = {pixel[23:18], 2'b00};
      2'd1:    pix_byte = {pixel[15:10], 2'b00};
      default: pix_byte = {pixel[7:2], 2'b00};
    endcase
  end
`else
  logic unused_bits;
  assign unused_bits = ^{pixel[18:16], pixel[9:8], pixel[2:0]};

  always_comb begin
    pix_byte = 8'h00;
    if (byte_idx == 1'b0) pix_byte = {pixel[23:19], pixel[15:13]};
    else                  pix_byte = {pixel[12:10], pixel[7:3]};
  end
`endif

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Frame scheduler: serves host byte writes between frames and streams window setup plus
// packed pixels to the byte-write engine. Pixel format follows LCD_SCHED_RGB666_EN.
module lcd_frame_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_done,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  input  logic        host_req,
  input  logic        host_rs,
  input  logic [7:0]  host_byte,
  output logic        host_ack,
  output logic        bus_valid,
  output logic        bus_rs,
  output logic [7:0]  bus_byte,
  input  logic        bus_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam logic [15:0] H_LAST    = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST    = 16'(V_RES - 1);
  localparam logic [8:0]  X_LAST    = 9'(H_RES - 1);
  localparam logic [7:0]  Y_LAST    = 8'(V_RES - 1);
  localparam byte_idx_t   BIDX_LAST = byte_idx_t'(BYTES_PER_PIX - 1);

  sched_state_e state_q;
  logic         bus_valid_q, bus_rs_q, frame_start_q, frame_done_q, pix_full_q;
  logic [7:0]   bus_byte_q, frame_cnt_q, y_q;
  logic [8:0]   x_q;
  logic [23:0]  pix_q;
  byte_idx_t    byte_idx_q;
  logic [2:0]   win_idx_q;

  logic         xfer, last_pix;
  logic [23:0]  pack_pix;
  byte_idx_t    pack_idx;
  logic [7:0]   pack_byte;

  assign xfer     = bus_valid_q & bus_ready;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  // An empty register packs byte 0 of the incoming pixel; a held one packs the next byte.
  assign pack_pix = pix_full_q ? pix_q : pix_data;
  assign pack_idx = pix_full_q ? byte_idx_q + byte_idx_t'(1) : '0;

  lcd_pix_pack u_pix_pack (
    .pixel    (pack_pix),
    .byte_idx (pack_idx),
    .pix_byte (pack_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      bus_valid_q   <= 1'b0;
      bus_rs_q      <= 1'b0;
      bus_byte_q    <= 8'h00;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= 8'h00;
      x_q           <= 9'd0;
      y_q           <= 8'd0;
      pix_full_q    <= 1'b0;
      pix_q         <= 24'h0;
      byte_idx_q    <= '0;
      win_idx_q     <= 3'd0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (state_q != StIdle && !init_done && (!bus_valid_q || bus_ready)) begin
        // Panel lost: let the presented byte finish, then drop the frame silently.
        state_q     <= StIdle;
        bus_valid_q <= 1'b0;
        pix_full_q  <= 1'b0;
        x_q         <= 9'd0;
        y_q         <= 8'd0;
        byte_idx_q  <= '0;
        win_idx_q   <= 3'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (init_done) begin
              if (host_req) begin
                state_q     <= StHost;
                bus_valid_q <= 1'b1;
                bus_rs_q    <= host_rs;
                bus_byte_q  <= host_byte;
              end else if (pix_valid) begin
                state_q       <= StCaset;
                frame_start_q <= 1'b1;
                bus_valid_q   <= 1'b1;
                bus_rs_q      <= 1'b0;
                bus_byte_q    <= CMD_CASET;
                win_idx_q     <= 3'd0;
              end
            end
          end
          StHost: begin
            if (xfer) begin
              state_q     <= StIdle;
              bus_valid_q <= 1'b0;
            end
          end
          StCaset, StPaset: begin
            if (xfer) begin
              if (win_idx_q == WIN_LAST) begin
                win_idx_q <= 3'd0;
                bus_rs_q  <= 1'b0;
                if (state_q == StCaset) begin
                  state_q    <= StPaset;
                  bus_byte_q <= CMD_PASET;
                end else begin
                  state_q    <= StRamwr;
                  bus_byte_q <= CMD_RAMWR;
                end
              end else begin
                win_idx_q  <= win_idx_q + 3'd1;
                bus_rs_q   <= 1'b1;
                bus_byte_q <= win_param((state_q == StCaset) ? H_LAST : V_LAST,
                                        win_idx_q + 3'd1);
              end
            end
          end
          StRamwr: begin
            if (xfer) begin
              state_q     <= StPixel;
              bus_valid_q <= 1'b0;
              pix_full_q  <= 1'b0;
            end
          end
          StPixel: begin
            if (!pix_full_q) begin
              if (pix_valid) begin
                pix_q       <= pix_data;
                pix_full_q  <= 1'b1;
                byte_idx_q  <= '0;
                bus_valid_q <= 1'b1;
                bus_rs_q    <= 1'b1;
                bus_byte_q  <= pack_byte;
              end
            end else if (xfer) begin
              if (byte_idx_q == BIDX_LAST) begin
                pix_full_q  <= 1'b0;
                bus_valid_q <= 1'b0;
                if (x_q == X_LAST) begin
                  x_q <= 9'd0;
                  y_q <= (y_q == Y_LAST) ? 8'd0 : y_q + 8'd1;
                end else begin
                  x_q <= x_q + 9'd1;
                end
                if (last_pix) begin
                  state_q      <= StFrameEnd;
                  frame_done_q <= 1'b1;
                  frame_cnt_q  <= frame_cnt_q + 8'd1;
                end
              end else begin
                byte_idx_q <= byte_idx_q + byte_idx_t'(1);
                bus_byte_q <= pack_byte;
              end
            end
          end
          StFrameEnd: state_q <= StIdle;
          default:    state_q <= StIdle;
        endcase
      end
    end
  end

  assign pix_ready   = (state_q == StPixel) && !pix_full_q;
  assign host_ack    = (state_q == StHost) && xfer;
  assign busy        = (state_q != StIdle);
  assign bus_valid   = bus_valid_q;
  assign bus_rs      = bus_rs_q;
  assign bus_byte    = bus_byte_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
